// File: rtl/histogram_builder.sv
// ---------------------------------------------------------------------------
// histogram_builder
//   Upstream stage of the Otsu threshold pipeline. Counts grey-level
//   occurrences over one frame of NUM_PIXELS pixels into NBINS = 2**PIXEL_W
//   bins, then streams every bin as (i, n_i) one per cycle in ascending order.
//   Bins are zeroed as they are streamed, so the next frame can start
//   accumulating immediately after the last beat.
//
//   Optional feature (macro HIST_SAT_EN):
//     defined   : bins saturate at all-ones. A sticky flag records that some
//                 bin saturated during the frame; when COUNT_W < 32 it is
//                 ORed into n_i[31] on the frame_done beat.
//     undefined : bins wrap modulo 2**COUNT_W.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   pixel        grey level of incoming pixel
//   pixel_valid  pixel qualifier
//   pixel_ready  block accepts a pixel this cycle (high in ACCUM only)
//   i            bin index being streamed
//   n_i          count of bin i, zero-extended to 32 bits
//   valid_out    i/n_i valid; NBINS consecutive beats per frame
//   frame_done   one-cycle pulse with the last beat (i = NBINS-1)
// ---------------------------------------------------------------------------
module histogram_builder #(
  parameter int PIXEL_W    = 8,
  parameter int COUNT_W    = 32,
  parameter int NUM_PIXELS = 65536
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PIXEL_W-1:0] pixel,
  input  logic               pixel_valid,
  output logic               pixel_ready,
  output logic [PIXEL_W-1:0] i,
  output logic [31:0]        n_i,
  output logic               valid_out,
  output logic               frame_done
);

  localparam int CNT_W = $clog2(NUM_PIXELS + 1);

  typedef enum logic [1:0] {CLEAR, ACCUM, STREAM} state_t;

  state_t               state_q;
  logic [PIXEL_W-1:0]   bin_idx_q;
  logic [CNT_W-1:0]     pix_cnt_q;
  logic                 ready_q, valid_q, done_q;
  logic [PIXEL_W-1:0]   i_q;
  logic [31:0]          n_q;

  // Bin storage; contents are not reset, CLEAR zeroes them after reset.
  logic [COUNT_W-1:0]   bins_q [2**PIXEL_W];

  logic                 accept;
  logic [COUNT_W-1:0]   cur_cnt, inc_cnt, rd_cnt;
  logic [31:0]          n_ext;
  logic                 we_d;
  logic [PIXEL_W-1:0]   waddr_d;
  logic [COUNT_W-1:0]   wdata_d;
  logic                 last_bin;

`ifdef HIST_SAT_EN
  localparam bit FLAG_EN = (COUNT_W < 32);
  logic                 at_max;
  logic                 sat_q, sat_frame_q;
`endif

  assign pixel_ready = ready_q;
  assign i           = i_q;
  assign n_i         = n_q;
  assign valid_out   = valid_q;
  assign frame_done  = done_q;

  always_comb begin
    accept   = pixel_valid && (state_q == ACCUM);
    last_bin = (bin_idx_q == '1);
    cur_cnt  = bins_q[pixel];
`ifdef HIST_SAT_EN
    at_max   = &cur_cnt;
    inc_cnt  = at_max ? cur_cnt : cur_cnt + COUNT_W'(1);
`else
    inc_cnt  = cur_cnt + COUNT_W'(1);
`endif
    rd_cnt   = bins_q[bin_idx_q];
    n_ext    = '0;
    n_ext[COUNT_W-1:0] = rd_cnt;

    // Single write port: CLEAR and STREAM zero bin_idx, ACCUM does the RMW.
    we_d     = 1'b0;
    waddr_d  = bin_idx_q;
    wdata_d  = '0;
    case (state_q)
      CLEAR, STREAM: we_d = 1'b1;
      ACCUM: begin
        we_d    = accept;
        waddr_d = pixel;
        wdata_d = inc_cnt;
      end
      default: we_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we_d) bins_q[waddr_d] <= wdata_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= CLEAR;
      bin_idx_q   <= '0;
      pix_cnt_q   <= '0;
      ready_q     <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      i_q         <= '0;
      n_q         <= '0;
`ifdef HIST_SAT_EN
      sat_q       <= 1'b0;
      sat_frame_q <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        CLEAR: begin
          bin_idx_q <= bin_idx_q + PIXEL_W'(1);
          if (last_bin) begin
            state_q <= ACCUM;
            ready_q <= 1'b1;
          end
        end
        ACCUM: begin
          if (accept) begin
`ifdef HIST_SAT_EN
            if (at_max) sat_q <= 1'b1;
`endif
            if (pix_cnt_q == CNT_W'(NUM_PIXELS - 1)) begin
              pix_cnt_q <= '0;
              bin_idx_q <= '0;
              state_q   <= STREAM;
              ready_q   <= 1'b0;
`ifdef HIST_SAT_EN
              // Latch this frame's flag (including the final accept) and
              // start the next frame clean.
              sat_frame_q <= sat_q | at_max;
              sat_q       <= 1'b0;
`endif
            end else begin
              pix_cnt_q <= pix_cnt_q + CNT_W'(1);
            end
          end
        end
        STREAM: begin
          i_q       <= bin_idx_q;
          n_q       <= n_ext;
          valid_q   <= 1'b1;
          bin_idx_q <= bin_idx_q + PIXEL_W'(1);
          if (last_bin) begin
            done_q  <= 1'b1;
            state_q <= ACCUM;
            ready_q <= 1'b1;
`ifdef HIST_SAT_EN
            n_q     <= n_ext | {(FLAG_EN && sat_frame_q), 31'b0};
`endif
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_histogram_builder.sv
module tb_histogram_builder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]  pix [3];
  logic        pv  [3];
  logic        rdy [3];
  logic [7:0]  io  [3];
  logic [31:0] n   [3];
  logic        vo  [3];
  logic        fd  [3];

  // u0: small frames, u1: 16-pixel frames, u2: 2-bit counters
  histogram_builder #(.PIXEL_W(8), .COUNT_W(32), .NUM_PIXELS(4)) u0 (
    .clk(clk), .reset(reset), .pixel(pix[0]), .pixel_valid(pv[0]),
    .pixel_ready(rdy[0]), .i(io[0]), .n_i(n[0]), .valid_out(vo[0]),
    .frame_done(fd[0]));
  histogram_builder #(.PIXEL_W(8), .COUNT_W(32), .NUM_PIXELS(16)) u1 (
    .clk(clk), .reset(reset), .pixel(pix[1]), .pixel_valid(pv[1]),
    .pixel_ready(rdy[1]), .i(io[1]), .n_i(n[1]), .valid_out(vo[1]),
    .frame_done(fd[1]));
  histogram_builder #(.PIXEL_W(8), .COUNT_W(2), .NUM_PIXELS(5)) u2 (
    .clk(clk), .reset(reset), .pixel(pix[2]), .pixel_valid(pv[2]),
    .pixel_ready(rdy[2]), .i(io[2]), .n_i(n[2]), .valid_out(vo[2]),
    .frame_done(fd[2]));

  int vectors = 0;
  int miscompares = 0;
  bit [7:0]    pq [$];
  int unsigned expb [256];
  bit          satf;
  int          cw [3];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected histogram of the frame in pq, from counting rules only.
  task automatic model(input int k);
    int unsigned mx;
    mx = (cw[k] == 32) ? 32'hFFFF_FFFF : ((32'd1 << cw[k]) - 1);
    for (int b = 0; b < 256; b++) expb[b] = 0;
    satf = 1'b0;
    foreach (pq[j]) begin
      if (expb[pq[j]] == mx) begin
`ifdef HIST_SAT_EN
        satf = 1'b1;
`else
        expb[pq[j]] = 0;
`endif
      end else begin
        expb[pq[j]] = expb[pq[j]] + 1;
      end
    end
  endtask

  task automatic wait_clear();
    for (int c = 1; c <= 256; c++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        chk("clear_rdy", 64'(rdy[k]), 64'(c == 256));
        chk("clear_out", {vo[k], fd[k], io[k], n[k]}, 64'd0);
      end
    end
  endtask

  // Feed pq to DUT k with random gaps; optionally keep driving junk after.
  task automatic send(input int k, input int gapmax, input bit junk);
    int budget;
    model(k);
    foreach (pq[j]) begin
      repeat ($urandom_range(gapmax, 0)) begin
        pv[k] = 1'b0;
        pix[k] = 8'($urandom);
        tick();
      end
      pix[k] = pq[j];
      pv[k]  = 1'b1;
      budget = 0;
      while (rdy[k] !== 1'b1 && budget < 600) begin
        tick();
        budget++;
      end
      if (budget >= 600) chk("rdy_timeout", 64'(rdy[k]), 64'd1);
      tick();
    end
    pv[k]  = junk;
    pix[k] = 8'($urandom);
  endtask

  // Check beats 0..nbeats-1; called right after the last-accept edge.
  task automatic stream(input int k, input int nbeats);
    logic [31:0] e;
    chk("latency_vo", 64'(vo[k]), 64'd0);
    for (int b = 0; b < nbeats; b++) begin
      tick();
      if (pv[k]) pix[k] = 8'($urandom);
      e = expb[b];
`ifdef HIST_SAT_EN
      if (b == 255 && satf && cw[k] < 32) e = e | 32'h8000_0000;
`endif
      chk("beat_vo", 64'(vo[k]), 64'd1);
      chk("beat_i", 64'(io[k]), 64'(b));
      chk("beat_n", 64'(n[k]), 64'(e));
      chk("beat_fd", 64'(fd[k]), 64'(b == 255));
      if (b < 255) chk("beat_rdy", 64'(rdy[k]), 64'd0);
    end
    pv[k] = 1'b0;
    if (nbeats == 256) begin
      tick();
      chk("post_vo", 64'(vo[k]), 64'd0);
      chk("post_fd", 64'(fd[k]), 64'd0);
      chk("post_rdy", 64'(rdy[k]), 64'd1);
    end
  endtask

  initial begin
    cw[0] = 32; cw[1] = 32; cw[2] = 2;
    for (int k = 0; k < 3; k++) begin pix[k] = '0; pv[k] = 1'b0; end

    // Reset state and CLEAR duration
    reset = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("reset_rdy", 64'(rdy[k]), 64'd0);
      chk("reset_out", {vo[k], fd[k], io[k], n[k]}, 64'd0);
    end
    reset = 1'b0;
    wait_clear();

    // 16 back-to-back pixels of 7
    pq = {};
    repeat (16) pq.push_back(8'd7);
    send(1, 0, 1'b0);
    stream(1, 256);

    // Boundary bins with valid gaps
    pq = {8'd0, 8'd255, 8'd3, 8'd3};
    send(0, 3, 1'b0);
    stream(0, 256);

    // Back-to-back frames, junk pixels during stream
    pq = {8'd9, 8'd9, 8'd9, 8'd9};
    send(0, 0, 1'b1);
    stream(0, 256);
    pq = {8'd10, 8'd10, 8'd10, 8'd10};
    send(0, 0, 1'b0);
    stream(0, 256);

    // Counter overflow (saturate or wrap)
    pq = {};
    repeat (5) pq.push_back(8'd1);
    send(2, 0, 1'b0);
    stream(2, 256);

    // Random frames
    for (int f = 0; f < 6; f++) begin
      pq = {};
      repeat (4) pq.push_back(8'($urandom));
      send(0, 2, 1'($urandom));
      stream(0, 256);
    end
    for (int f = 0; f < 3; f++) begin
      pq = {};
      repeat (16) pq.push_back(8'($urandom_range(7, 0)));
      send(1, 1, 1'($urandom));
      stream(1, 256);
    end
    for (int f = 0; f < 2; f++) begin
      pq = {};
      repeat (5) pq.push_back(8'($urandom_range(2, 0)));
      send(2, 1, 1'b0);
      stream(2, 256);
    end

    // Reset in the middle of a stream
    pq = {8'd50, 8'd50, 8'd60, 8'd70};
    send(0, 0, 1'b0);
    stream(0, 101);
    reset = 1'b1;
    #1;
    chk("midreset_vo", 64'(vo[0]), 64'd0);
    chk("midreset_fd", 64'(fd[0]), 64'd0);
    tick();
    reset = 1'b0;
    wait_clear();
    pq = {8'd1, 8'd2, 8'd3, 8'd60};
    send(0, 0, 1'b0);
    stream(0, 256);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
